// File: rtl/ibex_pkg.sv
// Shared types and constants for the register-file writeback buffer.
package ibex_pkg;

    localparam int unsigned RF_WB_ADDR_W        = 5;
    localparam int unsigned RF_WB_DATA_W        = 32;
    localparam int unsigned RF_WB_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [RF_WB_ADDR_W-1:0] addr;
        logic [RF_WB_DATA_W-1:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_fwd_match.sv
// Youngest-first match of one operand read address against the pending
// writeback entries, walking from the head (oldest) to the tail (youngest).
module ibex_rf_wb_fwd_match
    import ibex_pkg::*;
#(
    parameter int unsigned Depth     = RF_WB_DEPTH_DEFAULT,
    parameter int unsigned AddrWidth = RF_WB_ADDR_W,
    parameter int unsigned DataWidth = RF_WB_DATA_W,
    localparam int unsigned IdxWidth = $clog2(Depth),
    localparam int unsigned CntWidth = IdxWidth + 1
) (
    input  rf_wb_entry_t         entries_i [Depth],
    input  logic [IdxWidth-1:0]  head_i,
    input  logic [CntWidth-1:0]  count_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic                 hit_o,
    output logic [DataWidth-1:0] rdata_o
);

    logic [IdxWidth-1:0] idx;

    // Later (younger) matches overwrite earlier ones; x0 never matches.
    always_comb begin
        hit_o   = 1'b0;
        rdata_o = '0;
        idx     = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            idx = head_i + IdxWidth'(i);
            if ((CntWidth'(i) < count_i) && (raddr_i != '0) &&
                (AddrWidth'(entries_i[idx].addr) == raddr_i)) begin
                hit_o   = 1'b1;
                rdata_o = DataWidth'(entries_i[idx].data);
            end
        end
    end

endmodule

// File: rtl/ibex_rf_wb_buffer.sv
// In-order writeback buffer that drains into SRAM port 2 when it is idle and
// forwards pending data to operand reads. Optional same-cycle bypass when the
// buffer is empty: define IBEX_RF_WB_BYPASS_EN.
module ibex_rf_wb_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned DataWidth = RF_WB_DATA_W,
    parameter int unsigned Depth     = RF_WB_DEPTH_DEFAULT,
    parameter int unsigned AddrWidth = RF_WB_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wb_we_i,
    input  logic [AddrWidth-1:0]   wb_waddr_i,
    input  logic [DataWidth-1:0]   wb_wdata_i,
    output logic                   wb_ready_o,
    input  logic                   sram_busy_i,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_waddr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    input  logic [AddrWidth-1:0]   fwd_raddr_a_i,
    input  logic [AddrWidth-1:0]   fwd_raddr_b_i,
    output logic                   fwd_hit_a_o,
    output logic [DataWidth-1:0]   fwd_rdata_a_o,
    output logic                   fwd_hit_b_o,
    output logic [DataWidth-1:0]   fwd_rdata_b_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned IdxWidth = $clog2(Depth);
    localparam int unsigned PtrWidth = IdxWidth + 1;

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0] count_q, count_d;
    rf_wb_entry_t        mem_q [Depth];
    rf_wb_entry_t        mem_d [Depth];

    logic [IdxWidth-1:0] wr_idx, rd_idx;
    logic                full, empty, enq, deq, bypass;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    assign wr_idx = wr_ptr_q[IdxWidth-1:0];
    assign rd_idx = rd_ptr_q[IdxWidth-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IdxWidth] != rd_ptr_q[IdxWidth]);

    always_comb begin
        bypass = 1'b0;
`ifdef IBEX_RF_WB_BYPASS_EN
        bypass = empty && !sram_busy_i && wb_we_i && (wb_waddr_i != '0);
`endif
        deq = !empty && !sram_busy_i;
        enq = wb_we_i && !full && (wb_waddr_i != '0) && !bypass;
    end

    // Pointer, count and storage update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (enq) begin
            mem_d[wr_idx].addr = RF_WB_ADDR_W'(wb_waddr_i);
            mem_d[wr_idx].data = RF_WB_DATA_W'(wb_wdata_i);
            wr_ptr_d           = wr_ptr_q + PtrWidth'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + PtrWidth'(1);
            2'b01:   count_d = count_q - PtrWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // SRAM port 2 write: head entry when the port is free, else zeros.
    always_comb begin
        sram_we_o    = 1'b0;
        sram_waddr_o = '0;
        sram_wdata_o = '0;
        if (deq) begin
            sram_we_o    = 1'b1;
            sram_waddr_o = AddrWidth'(mem_q[rd_idx].addr);
            sram_wdata_o = DataWidth'(mem_q[rd_idx].data);
        end
`ifdef IBEX_RF_WB_BYPASS_EN
        if (bypass) begin
            sram_we_o    = 1'b1;
            sram_waddr_o = wb_waddr_i;
            sram_wdata_o = wb_wdata_i;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    ibex_rf_wb_fwd_match #(
        .Depth    (Depth),
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth)
    ) u_fwd_a (
        .entries_i(mem_q),
        .head_i   (rd_idx),
        .count_i  (count_q),
        .raddr_i  (fwd_raddr_a_i),
        .hit_o    (fwd_hit_a_o),
        .rdata_o  (fwd_rdata_a_o)
    );

    ibex_rf_wb_fwd_match #(
        .Depth    (Depth),
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth)
    ) u_fwd_b (
        .entries_i(mem_q),
        .head_i   (rd_idx),
        .count_i  (count_q),
        .raddr_i  (fwd_raddr_b_i),
        .hit_o    (fwd_hit_b_o),
        .rdata_o  (fwd_rdata_b_o)
    );

    assign wb_ready_o = !full;
    assign empty_o    = empty;
    assign count_o    = count_q;

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Bench for ibex_rf_wb_buffer: directed vector table, reset and ordering
// sequences, and random traffic against a queue-based reference model.
module tb_ibex_rf_wb_buffer;

    localparam int DEPTH = 2;
    localparam int NV    = 19;

    logic        clk;
    logic        rst_ni;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        wb_ready_o;
    logic        sram_busy_i;
    logic        sram_we_o;
    logic [4:0]  sram_waddr_o;
    logic [31:0] sram_wdata_o;
    logic [4:0]  fwd_raddr_a_i;
    logic [4:0]  fwd_raddr_b_i;
    logic        fwd_hit_a_o;
    logic [31:0] fwd_rdata_a_o;
    logic        fwd_hit_b_o;
    logic [31:0] fwd_rdata_b_o;
    logic        empty_o;
    logic [1:0]  count_o;

    ibex_rf_wb_buffer dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .wb_we_i      (wb_we_i),
        .wb_waddr_i   (wb_waddr_i),
        .wb_wdata_i   (wb_wdata_i),
        .wb_ready_o   (wb_ready_o),
        .sram_busy_i  (sram_busy_i),
        .sram_we_o    (sram_we_o),
        .sram_waddr_o (sram_waddr_o),
        .sram_wdata_o (sram_wdata_o),
        .fwd_raddr_a_i(fwd_raddr_a_i),
        .fwd_raddr_b_i(fwd_raddr_b_i),
        .fwd_hit_a_o  (fwd_hit_a_o),
        .fwd_rdata_a_o(fwd_rdata_a_o),
        .fwd_hit_b_o  (fwd_hit_b_o),
        .fwd_rdata_b_o(fwd_rdata_b_o),
        .empty_o      (empty_o),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        busy;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rdy;
        logic [1:0]  cnt;
        logic        swe;
        logic [4:0]  swa;
        logic [31:0] swd;
        logic        ha;
        logic [31:0] da;
        logic        hb;
        logic [31:0] db;
    } vec_t;

    vec_t tbl [NV];
    ent_t q[$];
    ent_t obs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Youngest pending write to address a, as architectural order demands.
    function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a == 5'd0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == a) begin
                h = 1'b1;
                d = q[i].data;
                return;
            end
        end
    endfunction

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic busy, input logic [4:0] ra, input logic [4:0] rb,
                         output logic acc);
        logic        full, drain, byp, ha, hb;
        logic [31:0] da, db;
        logic [37:0] exp_sram;
        @(negedge clk);
        wb_we_i       = we;
        wb_waddr_i    = wa;
        wb_wdata_i    = wd;
        sram_busy_i   = busy;
        fwd_raddr_a_i = ra;
        fwd_raddr_b_i = rb;
        #1;
        full  = (q.size() == DEPTH);
        drain = (q.size() != 0) && !busy;
        byp   = 1'b0;
`ifdef IBEX_RF_WB_BYPASS_EN
        byp = (q.size() == 0) && !busy && we && (wa != 5'd0);
`endif
        exp_sram = '0;
        if (drain) exp_sram = {1'b1, q[0].addr, q[0].data};
        else if (byp) exp_sram = {1'b1, wa, wd};
        lookup(ra, ha, da);
        lookup(rb, hb, db);
        chk("ready", wb_ready_o, !full);
        chk("count", count_o, q.size());
        chk("empty", empty_o, q.size() == 0);
        chk("sram", {sram_we_o, sram_waddr_o, sram_wdata_o}, exp_sram);
        chk("fwd_a", {fwd_hit_a_o, fwd_rdata_a_o}, {ha, da});
        chk("fwd_b", {fwd_hit_b_o, fwd_rdata_b_o}, {hb, db});
        if (sram_we_o) obs.push_back({sram_waddr_o, sram_wdata_o});
        acc = we && !full && (wa != 5'd0);
        if (drain) void'(q.pop_front());
        if (acc && !byp) q.push_back({wa, wd});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   n;
        int   cyc;

        //          we  wa     wd            busy ra     rb     rdy cnt   swe swa    swd           ha  da            hb  db
        tbl[0]  = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
`ifdef IBEX_RF_WB_BYPASS_EN
        tbl[1]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd0, 1, 2'd0, 1, 5'd5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0};
        tbl[2]  = '{0, 5'd0, 32'h0,        0, 5'd5, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
`else
        tbl[1]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[2]  = '{0, 5'd0, 32'h0,        0, 5'd5, 5'd0, 1, 2'd1, 1, 5'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0};
`endif
        tbl[3]  = '{0, 5'd0, 32'h0,        0, 5'd5, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[4]  = '{1, 5'd3, 32'h11,       1, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[5]  = '{1, 5'd4, 32'h22,       1, 5'd3, 5'd4, 1, 2'd1, 0, 5'd0, 32'h0,        1, 32'h11,       0, 32'h0};
        tbl[6]  = '{1, 5'd6, 32'h33,       1, 5'd3, 5'd4, 0, 2'd2, 0, 5'd0, 32'h0,        1, 32'h11,       1, 32'h22};
        tbl[7]  = '{1, 5'd6, 32'h33,       0, 5'd3, 5'd4, 0, 2'd2, 1, 5'd3, 32'h11,       1, 32'h11,       1, 32'h22};
        tbl[8]  = '{1, 5'd6, 32'h33,       0, 5'd0, 5'd0, 1, 2'd1, 1, 5'd4, 32'h22,       0, 32'h0,        0, 32'h0};
        tbl[9]  = '{0, 5'd0, 32'h0,        0, 5'd6, 5'd0, 1, 2'd1, 1, 5'd6, 32'h33,       1, 32'h33,       0, 32'h0};
        tbl[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[11] = '{1, 5'd7, 32'hA,        1, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[12] = '{1, 5'd7, 32'hB,        1, 5'd7, 5'd8, 1, 2'd1, 0, 5'd0, 32'h0,        1, 32'hA,        0, 32'h0};
        tbl[13] = '{0, 5'd0, 32'h0,        1, 5'd7, 5'd8, 0, 2'd2, 0, 5'd0, 32'h0,        1, 32'hB,        0, 32'h0};
        tbl[14] = '{0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 0, 2'd2, 1, 5'd7, 32'hA,        1, 32'hB,        0, 32'h0};
        tbl[15] = '{0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 1, 2'd1, 1, 5'd7, 32'hB,        1, 32'hB,        0, 32'h0};
        tbl[16] = '{0, 5'd0, 32'h0,        0, 5'd7, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[17] = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};
        tbl[18] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 1, 2'd0, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0};

        rst_ni        = 1'b0;
        wb_we_i       = 1'b0;
        wb_waddr_i    = '0;
        wb_wdata_i    = '0;
        sram_busy_i   = 1'b0;
        fwd_raddr_a_i = '0;
        fwd_raddr_b_i = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Directed vectors: outputs sampled before the edge that consumes the row.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wb_we_i       = tbl[i].we;
            wb_waddr_i    = tbl[i].wa;
            wb_wdata_i    = tbl[i].wd;
            sram_busy_i   = tbl[i].busy;
            fwd_raddr_a_i = tbl[i].ra;
            fwd_raddr_b_i = tbl[i].rb;
            #1;
            chk($sformatf("row%0d_ready", i), wb_ready_o, tbl[i].rdy);
            chk($sformatf("row%0d_count", i), count_o, tbl[i].cnt);
            chk($sformatf("row%0d_empty", i), empty_o, tbl[i].cnt == 2'd0);
            chk($sformatf("row%0d_sram", i), {sram_we_o, sram_waddr_o, sram_wdata_o},
                {tbl[i].swe, tbl[i].swa, tbl[i].swd});
            chk($sformatf("row%0d_fwd_a", i), {fwd_hit_a_o, fwd_rdata_a_o}, {tbl[i].ha, tbl[i].da});
            chk($sformatf("row%0d_fwd_b", i), {fwd_hit_b_o, fwd_rdata_b_o}, {tbl[i].hb, tbl[i].db});
        end

        // Asynchronous reset in the middle of a cycle with two entries queued.
        cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 5'd0, acc);
        cycle(1'b1, 5'd10, 32'hAA, 1'b1, 5'd0, 5'd0, acc);
        @(negedge clk);
        wb_we_i       = 1'b0;
        sram_busy_i   = 1'b1;
        fwd_raddr_a_i = 5'd9;
        fwd_raddr_b_i = 5'd10;
        #1;
        chk("pre_rst_count", count_o, 2);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_ready", wb_ready_o, 1);
        chk("rst_sram", {sram_we_o, sram_waddr_o, sram_wdata_o}, 38'd0);
        chk("rst_fwd_a", {fwd_hit_a_o, fwd_rdata_a_o}, 33'd0);
        chk("rst_fwd_b", {fwd_hit_b_o, fwd_rdata_b_o}, 33'd0);
        q.delete();
        #1;
        rst_ni = 1'b1;
        repeat (3) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd10, acc);

        // Alternating busy with held requests x1..x8: SRAM order and data.
        obs.delete();
        n   = 1;
        cyc = 0;
        while (n <= 8 && cyc < 100) begin
            cycle(1'b1, 5'(n), 32'h100 + 32'(n), (cyc % 2) == 0, 5'(n), 5'(n - 1), acc);
            chk("count_bound", 64'(count_o <= 2'(DEPTH)), 64'd1);
            if (acc) n++;
            cyc++;
        end
        chk("seq_accept_timeout", n, 9);
        while (q.size() != 0 && cyc < 200) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, acc);
            cyc++;
        end
        chk("seq_len", obs.size(), 8);
        for (int i = 0; i < obs.size() && i < 8; i++) begin
            chk($sformatf("seq%0d_addr", i), obs[i].addr, i + 1);
            chk($sformatf("seq%0d_data", i), obs[i].data, 32'h100 + 32'(i + 1));
        end

        // Random traffic over a small address range to exercise forwarding.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
        end
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, acc);
            cyc++;
        end
        chk("final_drain", q.size(), 0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
